bm_input_stage: RTL and testbench

Per-master-port address-phase holding stage of the AHB bus matrix, placed between a master's slave interface and the address decoder, whose requests feed the per-output round-robin arbiters. When the addressed output is not granted to this port or not ready, the stage registers the address phase, stalls the master's data phase, and re-presents the held transfer until the output accepts it. When granted and ready, transfers pass through with zero added latency.

---
 rtl/bm_ahb_pkg.sv | 39 +++
 rtl/bm_input_hold_reg.sv | 51 +++++
 rtl/bm_input_stage.sv | 112 +++++++++++
 tb/tb_bm_input_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bm_ahb_pkg.sv
// Shared AHB encodings and types for the bus-matrix input stage.
// The burst-restart option is enabled with the BM_INPUT_BURST_RESTART_EN macro.
package bm_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    typedef struct packed {
        logic [1:0] htrans;
        logic       hwrite;
        logic [2:0] hsize;
        logic [2:0] hburst;
        logic [3:0] hprot;
        logic       hmastlock;
    } bm_ctrl_t;

    // Only NONSEQ/SEQ carry an address phase that needs routing.
    function automatic logic trans_active(input logic [1:0] htrans);
        return htrans[1];
    endfunction

endpackage

// File: rtl/bm_input_hold_reg.sv
// Enable-loaded address/control holding register for a stalled address phase.
// With BM_INPUT_BURST_RESTART_EN, a held SEQ beat is re-presented as NONSEQ INCR.
module bm_input_hold_reg
    import bm_ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  bm_ctrl_t              ctrl_in,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output bm_ctrl_t              ctrl_out
);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    bm_ctrl_t              ctrl_q, ctrl_d;

    always_comb begin
        addr_d = addr_q;
        ctrl_d = ctrl_q;
        if (load) begin
            addr_d = addr_in;
            ctrl_d = ctrl_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            ctrl_q <= '0;
        end else begin
            addr_q <= addr_d;
            ctrl_q <= ctrl_d;
        end
    end

    always_comb begin
        addr_out = addr_q;
        ctrl_out = ctrl_q;
`ifdef BM_INPUT_BURST_RESTART_EN
        // The arbiter's burst counter must restart on a broken burst.
        if (ctrl_q.htrans == HTRANS_SEQ) begin
            ctrl_out.htrans = HTRANS_NONSEQ;
            ctrl_out.hburst = HBURST_INCR;
        end
`endif
    end

endmodule

// File: rtl/bm_input_stage.sv
// Per-master-port address-phase holding stage: passes granted transfers through
// combinationally, otherwise holds and re-presents them (see BM_INPUT_BURST_RESTART_EN).
module bm_input_stage
    import bm_ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSELS,
    input  logic [ADDR_WIDTH-1:0] HADDRS,
    input  logic [1:0]            HTRANSS,
    input  logic                  HWRITES,
    input  logic [2:0]            HSIZES,
    input  logic [2:0]            HBURSTS,
    input  logic [3:0]            HPROTS,
    input  logic                  HMASTLOCKS,
    input  logic                  HREADYS,
    input  logic                  active_trans,
    input  logic                  HREADYM,
    input  logic                  readyout_op,
    input  logic [1:0]            resp_op,
    output logic                  trans_valid,
    output logic [ADDR_WIDTH-1:0] HADDRI,
    output logic [1:0]            HTRANSI,
    output logic                  HWRITEI,
    output logic [2:0]            HSIZEI,
    output logic [2:0]            HBURSTI,
    output logic [3:0]            HPROTI,
    output logic                  HMASTLOCKI,
    output logic                  HREADYOUTS,
    output logic [1:0]            HRESPS
);

    logic [0:0] state_q, state_d;
    logic       data_phase_q, data_phase_d;

    logic                  live_valid;
    logic                  granted;
    logic                  pend;
    logic                  load;
    bm_ctrl_t              live_ctrl;
    bm_ctrl_t              hold_ctrl;
    bm_ctrl_t              mux_ctrl;
    logic [ADDR_WIDTH-1:0] hold_addr;

    assign live_valid = HSELS & HREADYS & trans_active(HTRANSS);
    assign granted    = active_trans & HREADYM;
    assign pend       = (state_q == ST_PEND);

    assign live_ctrl = '{htrans: HTRANSS, hwrite: HWRITES, hsize: HSIZES,
                         hburst: HBURSTS, hprot: HPROTS, hmastlock: HMASTLOCKS};

    always_comb begin
        state_d      = state_q;
        data_phase_d = data_phase_q;
        load         = 1'b0;
        if (data_phase_q && readyout_op) begin
            data_phase_d = 1'b0;
        end
        // A new acceptance overrides the data-phase completion above.
        if (pend) begin
            if (granted) begin
                state_d      = ST_IDLE;
                data_phase_d = 1'b1;
            end
        end else if (live_valid) begin
            if (granted) begin
                data_phase_d = 1'b1;
            end else begin
                load    = 1'b1;
                state_d = ST_PEND;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= ST_IDLE;
            data_phase_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_phase_q <= data_phase_d;
        end
    end

    bm_input_hold_reg #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_hold (
        .clk     (HCLK),
        .rst_n   (HRESETn),
        .load    (load),
        .addr_in (HADDRS),
        .ctrl_in (live_ctrl),
        .addr_out(hold_addr),
        .ctrl_out(hold_ctrl)
    );

    assign mux_ctrl    = pend ? hold_ctrl : live_ctrl;
    assign HADDRI      = pend ? hold_addr : HADDRS;
    assign HTRANSI     = mux_ctrl.htrans;
    assign HWRITEI     = mux_ctrl.hwrite;
    assign HSIZEI      = mux_ctrl.hsize;
    assign HBURSTI     = mux_ctrl.hburst;
    assign HPROTI      = mux_ctrl.hprot;
    assign HMASTLOCKI  = mux_ctrl.hmastlock;
    assign trans_valid = pend | live_valid;

    assign HREADYOUTS = pend ? 1'b0 : (data_phase_q ? readyout_op : 1'b1);
    assign HRESPS     = (pend || !data_phase_q) ? HRESP_OKAY : resp_op;

endmodule

// File: tb/tb_bm_input_stage.sv
// Table-driven bench for bm_input_stage; expected values follow BM_INPUT_BURST_RESTART_EN.
module tb_bm_input_stage;

    typedef struct {
        logic        hsel;
        logic [1:0]  htrans;
        logic [31:0] addr;
        logic        hwrite;
        logic [2:0]  hburst;
        logic        hready_s;
        logic        act;
        logic        hreadym;
        logic        rdyo;
        logic [1:0]  resp;
        logic        e_tv;
        logic [31:0] e_addr;
        logic [1:0]  e_trans;
        logic [2:0]  e_burst;
        logic        e_write;
        logic        e_rdy;
        logic [1:0]  e_resp;
    } vec_t;

`ifdef BM_INPUT_BURST_RESTART_EN
    localparam logic [1:0] HELD_SEQ_TRANS = 2'b10;
    localparam logic [2:0] HELD_SEQ_BURST = 3'b001;
`else
    localparam logic [1:0] HELD_SEQ_TRANS = 2'b11;
    localparam logic [2:0] HELD_SEQ_BURST = 3'b011;
`endif

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSELS;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic        HWRITES;
    logic [2:0]  HSIZES;
    logic [2:0]  HBURSTS;
    logic [3:0]  HPROTS;
    logic        HMASTLOCKS;
    logic        HREADYS;
    logic        active_trans;
    logic        HREADYM;
    logic        readyout_op;
    logic [1:0]  resp_op;
    logic        trans_valid;
    logic [31:0] HADDRI;
    logic [1:0]  HTRANSI;
    logic        HWRITEI;
    logic [2:0]  HSIZEI;
    logic [2:0]  HBURSTI;
    logic [3:0]  HPROTI;
    logic        HMASTLOCKI;
    logic        HREADYOUTS;
    logic [1:0]  HRESPS;

    int n_vec = 0;
    int n_err = 0;

    always #5 HCLK = ~HCLK;

    bm_input_stage #(.ADDR_WIDTH(32)) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HSELS       (HSELS),
        .HADDRS      (HADDRS),
        .HTRANSS     (HTRANSS),
        .HWRITES     (HWRITES),
        .HSIZES      (HSIZES),
        .HBURSTS     (HBURSTS),
        .HPROTS      (HPROTS),
        .HMASTLOCKS  (HMASTLOCKS),
        .HREADYS     (HREADYS),
        .active_trans(active_trans),
        .HREADYM     (HREADYM),
        .readyout_op (readyout_op),
        .resp_op     (resp_op),
        .trans_valid (trans_valid),
        .HADDRI      (HADDRI),
        .HTRANSI     (HTRANSI),
        .HWRITEI     (HWRITEI),
        .HSIZEI      (HSIZEI),
        .HBURSTI     (HBURSTI),
        .HPROTI      (HPROTI),
        .HMASTLOCKI  (HMASTLOCKI),
        .HREADYOUTS  (HREADYOUTS),
        .HRESPS      (HRESPS)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t v(
        input logic hsel, input logic [1:0] tr, input logic [31:0] a, input logic w,
        input logic [2:0] b, input logic hrs, input logic act, input logic hm,
        input logic ro, input logic [1:0] rs,
        input logic etv, input logic [31:0] ea, input logic [1:0] et,
        input logic [2:0] eb, input logic ew, input logic er, input logic [1:0] ers);
        vec_t r;
        r.hsel = hsel; r.htrans = tr; r.addr = a; r.hwrite = w; r.hburst = b;
        r.hready_s = hrs; r.act = act; r.hreadym = hm; r.rdyo = ro; r.resp = rs;
        r.e_tv = etv; r.e_addr = ea; r.e_trans = et; r.e_burst = eb;
        r.e_write = ew; r.e_rdy = er; r.e_resp = ers;
        return r;
    endfunction

    task automatic drive(input vec_t x);
        HSELS        = x.hsel;
        HTRANSS      = x.htrans;
        HADDRS       = x.addr;
        HWRITES      = x.hwrite;
        HBURSTS      = x.hburst;
        HREADYS      = x.hready_s;
        active_trans = x.act;
        HREADYM      = x.hreadym;
        readyout_op  = x.rdyo;
        resp_op      = x.resp;
    endtask

    task automatic drive_idle(input logic hrs, input logic act, input logic hm);
        drive(v(1'b1, 2'b00, 32'h0, 1'b0, 3'b000, hrs, act, hm, 1'b0, 2'b00,
                1'b0, 32'h0, 2'b00, 3'b000, 1'b0, 1'b1, 2'b00));
    endtask

    vec_t tbl[$];
    vec_t sb[$];
    vec_t exp_v;

    initial begin
        HRESETn    = 1'b0;
        HSIZES     = 3'b010;
        HPROTS     = 4'b0011;
        HMASTLOCKS = 1'b0;
        drive_idle(1'b1, 1'b0, 1'b1);

        // Columns: hsel trans addr wr burst hreadys act hreadym rdyo resp | tv addr trans burst wr rdy resp
        // Pass-through, granted and ready
        tbl.push_back(v(1,2'b10,32'h1000,0,3'b000,1,1,1,0,2'b00, 1,32'h1000,2'b10,3'b000,0,1,2'b00));
        tbl.push_back(v(1,2'b00,32'h0,   0,3'b000,1,0,1,0,2'b00, 0,32'h0,   2'b00,3'b000,0,0,2'b00));
        tbl.push_back(v(1,2'b00,32'h0,   0,3'b000,1,0,1,1,2'b00, 0,32'h0,   2'b00,3'b000,0,1,2'b00));
        tbl.push_back(v(1,2'b00,32'h0,   0,3'b000,1,0,1,0,2'b00, 0,32'h0,   2'b00,3'b000,0,1,2'b00));
        // Not granted for 3 cycles; live bus changes while held
        tbl.push_back(v(1,2'b10,32'h2000,1,3'b000,1,0,1,0,2'b00, 1,32'h2000,2'b10,3'b000,1,1,2'b00));
        tbl.push_back(v(1,2'b00,32'h3000,0,3'b000,0,0,1,0,2'b00, 1,32'h2000,2'b10,3'b000,1,0,2'b00));
        tbl.push_back(v(1,2'b00,32'h3000,0,3'b000,0,0,1,0,2'b00, 1,32'h2000,2'b10,3'b000,1,0,2'b00));
        tbl.push_back(v(1,2'b00,32'h3000,0,3'b000,0,1,1,0,2'b00, 1,32'h2000,2'b10,3'b000,1,0,2'b00));
        tbl.push_back(v(1,2'b00,32'h0,   0,3'b000,1,0,1,1,2'b00, 0,32'h0,   2'b00,3'b000,0,1,2'b00));
        // Granted but HREADYM low for 2 cycles
        tbl.push_back(v(1,2'b10,32'h4000,0,3'b000,1,1,0,0,2'b00, 1,32'h4000,2'b10,3'b000,0,1,2'b00));
        tbl.push_back(v(1,2'b00,32'h0,   0,3'b000,0,1,0,0,2'b00, 1,32'h4000,2'b10,3'b000,0,0,2'b00));
        tbl.push_back(v(1,2'b00,32'h0,   0,3'b000,0,1,1,0,2'b00, 1,32'h4000,2'b10,3'b000,0,0,2'b00));
        tbl.push_back(v(1,2'b00,32'h0,   0,3'b000,1,0,1,1,2'b00, 0,32'h0,   2'b00,3'b000,0,1,2'b00));
        // Held SEQ INCR4 beat
        tbl.push_back(v(1,2'b11,32'h5004,0,3'b011,1,0,1,0,2'b00, 1,32'h5004,2'b11,3'b011,0,1,2'b00));
        tbl.push_back(v(1,2'b00,32'h0,   0,3'b000,0,1,1,0,2'b00, 1,32'h5004,HELD_SEQ_TRANS,HELD_SEQ_BURST,0,0,2'b00));
        tbl.push_back(v(1,2'b00,32'h0,   0,3'b000,1,0,1,1,2'b00, 0,32'h0,   2'b00,3'b000,0,1,2'b00));
        // Two-cycle ERROR response
        tbl.push_back(v(1,2'b10,32'h6000,1,3'b000,1,1,1,0,2'b00, 1,32'h6000,2'b10,3'b000,1,1,2'b00));
        tbl.push_back(v(1,2'b00,32'h0,   0,3'b000,1,0,1,0,2'b01, 0,32'h0,   2'b00,3'b000,0,0,2'b01));
        tbl.push_back(v(1,2'b00,32'h0,   0,3'b000,1,0,1,1,2'b01, 0,32'h0,   2'b00,3'b000,0,1,2'b01));
        tbl.push_back(v(1,2'b00,32'h0,   0,3'b000,1,0,1,0,2'b01, 0,32'h0,   2'b00,3'b000,0,1,2'b00));
        // New acceptance in the same cycle the data phase completes
        tbl.push_back(v(1,2'b10,32'h7000,0,3'b001,1,1,1,0,2'b00, 1,32'h7000,2'b10,3'b001,0,1,2'b00));
        tbl.push_back(v(1,2'b11,32'h7004,0,3'b001,1,1,1,1,2'b00, 1,32'h7004,2'b11,3'b001,0,1,2'b00));
        tbl.push_back(v(1,2'b00,32'h0,   0,3'b000,1,0,1,0,2'b00, 0,32'h0,   2'b00,3'b000,0,0,2'b00));
        tbl.push_back(v(1,2'b00,32'h0,   0,3'b000,1,0,1,1,2'b00, 0,32'h0,   2'b00,3'b000,0,1,2'b00));
        // BUSY and deselected transfers are never captured
        tbl.push_back(v(1,2'b01,32'h8000,0,3'b001,1,0,1,0,2'b00, 0,32'h8000,2'b01,3'b001,0,1,2'b00));
        tbl.push_back(v(1,2'b00,32'h0,   0,3'b000,1,0,1,0,2'b00, 0,32'h0,   2'b00,3'b000,0,1,2'b00));
        tbl.push_back(v(0,2'b10,32'h8100,0,3'b000,1,0,1,0,2'b00, 0,32'h8100,2'b10,3'b000,0,1,2'b00));
        tbl.push_back(v(1,2'b00,32'h0,   0,3'b000,1,0,1,0,2'b00, 0,32'h0,   2'b00,3'b000,0,1,2'b00));

        #7;
        chk("reset_hreadyouts", {31'b0, HREADYOUTS}, 32'd1);
        chk("reset_hresps", {30'b0, HRESPS}, 32'd0);
        chk("reset_trans_valid", {31'b0, trans_valid}, 32'd0);
        #5 HRESETn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge HCLK);
            #1;
            drive(tbl[i]);
            sb.push_back(tbl[i]);
            @(negedge HCLK);
            exp_v = sb.pop_front();
            chk($sformatf("v%0d_trans_valid", i), {31'b0, trans_valid}, {31'b0, exp_v.e_tv});
            chk($sformatf("v%0d_haddri", i), HADDRI, exp_v.e_addr);
            chk($sformatf("v%0d_htransi", i), {30'b0, HTRANSI}, {30'b0, exp_v.e_trans});
            chk($sformatf("v%0d_hbursti", i), {29'b0, HBURSTI}, {29'b0, exp_v.e_burst});
            chk($sformatf("v%0d_hwritei", i), {31'b0, HWRITEI}, {31'b0, exp_v.e_write});
            chk($sformatf("v%0d_hreadyouts", i), {31'b0, HREADYOUTS}, {31'b0, exp_v.e_rdy});
            chk($sformatf("v%0d_hresps", i), {30'b0, HRESPS}, {30'b0, exp_v.e_resp});
            $display("vec %0d: addr=0x%0h tv=%0b haddri=0x%0h htransi=%0b hreadyouts=%0b hresps=%0b",
                     i, exp_v.addr, trans_valid, HADDRI, HTRANSI, HREADYOUTS, HRESPS);
        end

        // Reset while a transfer is held: it must be discarded
        @(posedge HCLK);
        #1;
        drive(v(1,2'b10,32'h9000,1,3'b000,1,0,1,0,2'b00, 0,0,0,0,0,0,0));
        @(negedge HCLK);
        chk("rst_seq_capture_tv", {31'b0, trans_valid}, 32'd1);
        @(posedge HCLK);
        #1;
        drive_idle(1'b0, 1'b0, 1'b1);
        @(negedge HCLK);
        chk("rst_seq_pend_hready", {31'b0, HREADYOUTS}, 32'd0);
        chk("rst_seq_pend_addr", HADDRI, 32'h9000);
        #2;
        HRESETn = 1'b0;
        drive_idle(1'b1, 1'b1, 1'b1);
        #1;
        chk("rst_seq_async_hready", {31'b0, HREADYOUTS}, 32'd1);
        chk("rst_seq_async_tv", {31'b0, trans_valid}, 32'd0);
        chk("rst_seq_async_hresps", {30'b0, HRESPS}, 32'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge HCLK);
            chk($sformatf("rst_seq_noissue_tv%0d", k), {31'b0, trans_valid}, 32'd0);
            chk($sformatf("rst_seq_noissue_hready%0d", k), {31'b0, HREADYOUTS}, 32'd1);
            chk($sformatf("rst_seq_noissue_addr%0d", k), HADDRI, 32'h0);
            $display("post-reset cycle %0d: tv=%0b haddri=0x%0h hreadyouts=%0b",
                     k, trans_valid, HADDRI, HREADYOUTS);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
